// File: rtl/seq_packet_serializer.sv
// Sequence-packet serializer: buffers one multi-lane packet and emits its valid lanes one per cycle,
// accumulating ll+ml per job and reporting the job length on end-of-job.
module seq_packet_serializer #(
    parameter int SEQ_PACKET_SIZE = 4,
    parameter int LL_BITS         = 17,
    parameter int ML_BITS         = 17,
    parameter int OFFSET_BITS     = 26,
    parameter int JOB_LEN_BITS    = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_seq_packet_valid,
    input  logic [SEQ_PACKET_SIZE-1:0]             i_seq_packet_strb,
    input  logic [SEQ_PACKET_SIZE*LL_BITS-1:0]     i_seq_packet_ll,
    input  logic [SEQ_PACKET_SIZE*ML_BITS-1:0]     i_seq_packet_ml,
    input  logic [SEQ_PACKET_SIZE*OFFSET_BITS-1:0] i_seq_packet_offset,
    input  logic [SEQ_PACKET_SIZE*ML_BITS-1:0]     i_seq_packet_overlap,
    input  logic [SEQ_PACKET_SIZE-1:0]             i_seq_packet_eoj,
    input  logic [SEQ_PACKET_SIZE-1:0]             i_seq_packet_delim,
    output logic                                   i_seq_packet_ready,
    output logic                                   o_seq_valid,
    output logic [LL_BITS-1:0]                     o_seq_ll,
    output logic [ML_BITS-1:0]                     o_seq_ml,
    output logic [OFFSET_BITS-1:0]                 o_seq_offset,
    output logic [ML_BITS-1:0]                     o_seq_overlap,
    output logic                                   o_seq_eoj,
    output logic                                   o_seq_delim,
    input  logic                                   o_seq_ready,
    output logic                                   o_job_len_valid,
    output logic [JOB_LEN_BITS-1:0]                o_job_len
);

    localparam int SPS   = SEQ_PACKET_SIZE;
    localparam int SEL_W = (SPS > 1) ? $clog2(SPS) : 1;

    typedef enum logic {
        ST_EMPTY,
        ST_DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [SPS-1:0]          pend_q, pend_d;
    logic [LL_BITS-1:0]      ll_q      [SPS];
    logic [ML_BITS-1:0]      ml_q      [SPS];
    logic [OFFSET_BITS-1:0]  offset_q  [SPS];
    logic [ML_BITS-1:0]      overlap_q [SPS];
    logic [SPS-1:0]          eoj_q;
    logic [SPS-1:0]          delim_q;
    logic [JOB_LEN_BITS-1:0] acc_q, acc_d;
    logic [JOB_LEN_BITS-1:0] job_len_q, job_len_d;
    logic                    job_len_valid_q, job_len_valid_d;

    logic [SEL_W-1:0]        sel;
    logic [SPS-1:0]          sel_bit;
    logic                    seq_hs;
    logic                    pkt_hs;
    logic [JOB_LEN_BITS-1:0] seq_sum;

    // Lowest pending lane goes first so lanes leave in ascending order.
    always_comb begin
        logic found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SPS; i++) begin
            if (pend_q[i] && !found) begin
                sel   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    assign sel_bit = pend_q & (-pend_q);

    assign o_seq_valid   = (state_q == ST_DRAIN);
    assign o_seq_ll      = ll_q[sel];
    assign o_seq_ml      = ml_q[sel];
    assign o_seq_offset  = offset_q[sel];
    assign o_seq_overlap = overlap_q[sel];
    assign o_seq_eoj     = eoj_q[sel];
    assign o_seq_delim   = delim_q[sel];

    assign o_job_len_valid = job_len_valid_q;
    assign o_job_len       = job_len_q;

    // Taking the final pending lane frees the buffer in the same cycle, so a new packet
    // can land without a bubble.
    assign i_seq_packet_ready = (state_q == ST_EMPTY) ||
                                ($onehot(pend_q) && o_seq_valid && o_seq_ready);

    assign seq_hs = o_seq_valid && o_seq_ready;
    assign pkt_hs = i_seq_packet_valid && i_seq_packet_ready;

    always_comb begin
        pend_d          = pend_q;
        acc_d           = acc_q;
        job_len_d       = job_len_q;
        job_len_valid_d = 1'b0;
        seq_sum         = acc_q + JOB_LEN_BITS'(o_seq_ll) + JOB_LEN_BITS'(o_seq_ml);

        if (seq_hs) begin
            pend_d = pend_q & ~sel_bit;
            if (o_seq_eoj) begin
                job_len_valid_d = 1'b1;
                job_len_d       = seq_sum;
                acc_d           = '0;
            end else begin
                acc_d = seq_sum;
            end
        end

        if (pkt_hs) begin
            pend_d = i_seq_packet_strb;
        end

        state_d = (pend_d == '0) ? ST_EMPTY : ST_DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_EMPTY;
            pend_q          <= '0;
            acc_q           <= '0;
            job_len_q       <= '0;
            job_len_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            acc_q           <= acc_d;
            job_len_q       <= job_len_d;
            job_len_valid_q <= job_len_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SPS; i++) begin
                ll_q[i]      <= '0;
                ml_q[i]      <= '0;
                offset_q[i]  <= '0;
                overlap_q[i] <= '0;
            end
            eoj_q   <= '0;
            delim_q <= '0;
        end else if (pkt_hs) begin
            for (int unsigned i = 0; i < SPS; i++) begin
                ll_q[i]      <= i_seq_packet_ll[i*LL_BITS +: LL_BITS];
                ml_q[i]      <= i_seq_packet_ml[i*ML_BITS +: ML_BITS];
                offset_q[i]  <= i_seq_packet_offset[i*OFFSET_BITS +: OFFSET_BITS];
                overlap_q[i] <= i_seq_packet_overlap[i*ML_BITS +: ML_BITS];
            end
            eoj_q   <= i_seq_packet_eoj;
            delim_q <= i_seq_packet_delim;
        end
    end

endmodule
